// File: rtl/arith_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Defines the shift operation encoding and the illegal-op range used
// by the top level to flag requests that must not produce a shifted result.
package arith_shifter_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    SHIFT_SLL = 3'd0,  // logical left, zero fill
    SHIFT_SRL = 3'd1,  // logical right, zero fill
    SHIFT_SRA = 3'd2,  // arithmetic right, MSB fill
    SHIFT_ROL = 3'd3,  // rotate left
    SHIFT_ROR = 3'd4   // rotate right
  } shift_op_t;

  // Every code from here to the top of the op field is illegal.
  localparam logic [OP_W-1:0] OP_ILLEGAL_FIRST = 3'd5;

  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op >= OP_ILLEGAL_FIRST;
  endfunction

endpackage

// File: rtl/arith_shifter_stage.sv
// One barrel-shifter pipeline stage: shifts by DIST when its amount bit is set.
// Latency: 1 cycle (result registered on the accepting edge).
// Backpressure: accepts when empty or when its contents leave on the same edge.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   prev_val/msg/amt/op/err  transaction offered by the upstream stage (or input)
//   next_rdy              downstream can take this stage's contents this edge
//   val/msg/amt/op/err    registered contents of this stage
module arith_shifter_stage
  import arith_shifter_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int DIST  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           prev_val,
  input  logic [NBITS-1:0]               prev_msg,
  input  logic [$clog2(NBITS)-1:0]       prev_amt,
  input  logic [OP_W-1:0]                prev_op,
  input  logic                           prev_err,
  input  logic                           next_rdy,
  output logic                           val,
  output logic [NBITS-1:0]               msg,
  output logic [$clog2(NBITS)-1:0]       amt,
  output logic [OP_W-1:0]                op,
  output logic                           err
);

  // Amount bit that selects this stage's shift.
  localparam int SEL = $clog2(DIST);

  logic             adv;
  logic             load;
  logic [NBITS-1:0] shifted;

  // Contents leave when downstream takes them; a new transaction can land
  // in the same edge, so an empty or draining stage is open for input.
  assign adv  = val && next_rdy;
  assign load = prev_val && (!val || next_rdy);

  // Shift mux works on the incoming data so the result is registered here.
  // Illegal ops arrive already zeroed and simply pass through.
  always_comb begin
    shifted = prev_msg;
    if (prev_amt[SEL]) begin
      case (prev_op)
        SHIFT_SLL: shifted = prev_msg << DIST;
        SHIFT_SRL: shifted = prev_msg >> DIST;
        SHIFT_SRA: shifted = $signed(prev_msg) >>> DIST;
        SHIFT_ROL: shifted = (prev_msg << DIST) | (prev_msg >> (NBITS - DIST));
        SHIFT_ROR: shifted = (prev_msg >> DIST) | (prev_msg << (NBITS - DIST));
        default:   shifted = prev_msg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val <= 1'b0;
      msg <= '0;
      amt <= '0;
      op  <= '0;
      err <= 1'b0;
    end else if (load) begin
      val <= 1'b1;
      msg <= shifted;
      amt <= prev_amt;
      op  <= prev_op;
      err <= prev_err;
    end else if (adv) begin
      // Payload registers keep their last value; only the valid bit drops.
      val <= 1'b0;
    end
  end

endmodule

// File: rtl/arith_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready on both sides.
// Latency: AMT_BITS cycles from acceptance to out_val, one result per cycle.
// Backpressure: bubbles collapse; in_rdy follows out_rdy combinationally when full.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   in_val/in_rdy                   request handshake
//   in_msg, in_amt, in_op           operand, unsigned shift amount, op code
//   out_val/out_rdy                 result handshake
//   out_msg, out_err                result data, illegal-op flag (data is 0 then)
module arith_shifter_pipe
  import arith_shifter_pkg::*;
#(
  parameter int NBITS    = 8,               // power of two, at least 4
  parameter int AMT_BITS = $clog2(NBITS)    // derived: amount width and depth
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [NBITS-1:0]    in_msg,
  input  logic [AMT_BITS-1:0] in_amt,
  input  logic [OP_W-1:0]     in_op,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [NBITS-1:0]    out_msg,
  output logic                out_err
);

  localparam int LAST = AMT_BITS - 1;

  logic                stg_val [AMT_BITS];
  logic [NBITS-1:0]    stg_msg [AMT_BITS];
  logic [AMT_BITS-1:0] stg_amt [AMT_BITS];
  logic [OP_W-1:0]     stg_op  [AMT_BITS];
  logic                stg_err [AMT_BITS];

  // down_rdy[k]: whatever sits after stage k can accept on this edge.
  logic [AMT_BITS-1:0] down_rdy;
  logic                in_illegal;

  // Ready chain built from the output back toward the input. A stage is
  // open to its upstream when it is empty or its own downstream is open.
  always_comb begin
    down_rdy       = '0;
    down_rdy[LAST] = out_rdy;
    for (int k = LAST; k > 0; k--) begin
      down_rdy[k-1] = !stg_val[k] || down_rdy[k];
    end
  end

  assign in_rdy     = !stg_val[0] || down_rdy[0];
  assign in_illegal = is_illegal_op(in_op);

  for (genvar k = 0; k < AMT_BITS; k++) begin : g_stage
    logic                p_val;
    logic [NBITS-1:0]    p_msg;
    logic [AMT_BITS-1:0] p_amt;
    logic [OP_W-1:0]     p_op;
    logic                p_err;

    if (k == 0) begin : g_head
      // Illegal requests are zeroed here so no later stage needs to care.
      assign p_val = in_val;
      assign p_msg = in_illegal ? '0 : in_msg;
      assign p_amt = in_amt;
      assign p_op  = in_op;
      assign p_err = in_illegal;
    end else begin : g_body
      assign p_val = stg_val[k-1];
      assign p_msg = stg_msg[k-1];
      assign p_amt = stg_amt[k-1];
      assign p_op  = stg_op[k-1];
      assign p_err = stg_err[k-1];
    end

    arith_shifter_stage #(
      .NBITS (NBITS),
      .DIST  (1 << k)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .prev_val (p_val),
      .prev_msg (p_msg),
      .prev_amt (p_amt),
      .prev_op  (p_op),
      .prev_err (p_err),
      .next_rdy (down_rdy[k]),
      .val      (stg_val[k]),
      .msg      (stg_msg[k]),
      .amt      (stg_amt[k]),
      .op       (stg_op[k]),
      .err      (stg_err[k])
    );
  end

  // The final stage's amount and op have no consumer.
  logic unused_tail;
  assign unused_tail = ^{stg_amt[LAST], stg_op[LAST]};

  assign out_val = stg_val[LAST];
  assign out_msg = stg_msg[LAST];
  assign out_err = stg_err[LAST];

endmodule

// File: tb/tb_arith_shifter_pipe.sv
// Testbench for arith_shifter_pipe: NBITS=8 and NBITS=32 instances sharing
// one stimulus bus, checked against a bit-level reference of the shift rules.
module tb_arith_shifter_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_val;
  logic        out_rdy;
  logic        sel32;
  logic [31:0] in_msg;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;

  logic        in_rdy8, out_val8, out_err8;
  logic [7:0]  out_msg8;
  logic        in_rdy32, out_val32, out_err32;
  logic [31:0] out_msg32;

  logic        cur_in_rdy, cur_out_val, cur_out_err;
  logic [31:0] cur_out_msg;

  int errors = 0;
  int checks = 0;

  arith_shifter_pipe #(.NBITS(8)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val & ~sel32),
    .in_rdy  (in_rdy8),
    .in_msg  (in_msg[7:0]),
    .in_amt  (in_amt[2:0]),
    .in_op   (in_op),
    .out_val (out_val8),
    .out_rdy (out_rdy),
    .out_msg (out_msg8),
    .out_err (out_err8)
  );

  arith_shifter_pipe #(.NBITS(32)) dut32 (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val & sel32),
    .in_rdy  (in_rdy32),
    .in_msg  (in_msg),
    .in_amt  (in_amt),
    .in_op   (in_op),
    .out_val (out_val32),
    .out_rdy (out_rdy),
    .out_msg (out_msg32),
    .out_err (out_err32)
  );

  assign cur_in_rdy  = sel32 ? in_rdy32  : in_rdy8;
  assign cur_out_val = sel32 ? out_val32 : out_val8;
  assign cur_out_err = sel32 ? out_err32 : out_err8;
  assign cur_out_msg = sel32 ? out_msg32 : {24'd0, out_msg8};

  // Reference: each result bit taken straight from its source bit position.
  // Returns {err, msg}.
  function automatic logic [32:0] model(input logic [31:0] d, input int amt,
                                        input int op, input int w);
    logic [31:0] r;
    int s;
    r = '0;
    if (op >= 5) return {1'b1, 32'd0};
    for (int i = 0; i < w; i++) begin
      case (op)
        0: begin s = i - amt; r[i] = (s >= 0) ? d[s] : 1'b0;       end
        1: begin s = i + amt; r[i] = (s < w)  ? d[s] : 1'b0;       end
        2: begin s = i + amt; r[i] = (s < w)  ? d[s] : d[w-1];     end
        3: begin s = (i - amt + w) % w; r[i] = d[s];               end
        default: begin s = (i + amt) % w; r[i] = d[s];             end
      endcase
    end
    return {1'b0, r};
  endfunction

  // Sends one request to the selected DUT and waits for its result.
  // lat counts cycles from the accepting edge inclusive; -1 on timeout.
  task automatic run_one(input logic [31:0] msg, input int amt, input int op,
                         output logic [31:0] omsg, output logic oerr, output int lat);
    bit acc;
    bit got;
    omsg = 'x;
    oerr = 1'bx;
    lat  = -1;
    acc  = 1'b0;
    got  = 1'b0;
    @(posedge clk); #1;
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = msg;
    in_amt  = 5'(amt);
    in_op   = 3'(op);
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = cur_in_rdy;
      @(posedge clk);
    end
    #1 in_val = 1'b0;
    if (acc) begin
      lat = 1;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (cur_out_val) begin
          omsg = cur_out_msg;
          oerr = cur_out_err;
          got  = 1'b1;
        end else begin
          @(posedge clk);
          lat++;
        end
      end
      if (!got) lat = -1;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    sel32   = 1'b0;
    in_msg  = '0;
    in_amt  = '0;
    in_op   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (out_val8 !== 1'b0) begin errors++; $display("FAIL reset_out_val8: got %b exp 0", out_val8); end
    checks++; if (out_msg8 !== 8'h00) begin errors++; $display("FAIL reset_out_msg8: got %h exp 00", out_msg8); end
    checks++; if (out_err8 !== 1'b0) begin errors++; $display("FAIL reset_out_err8: got %b exp 0", out_err8); end
    checks++; if (in_rdy8 !== 1'b1) begin errors++; $display("FAIL reset_in_rdy8: got %b exp 1", in_rdy8); end
    checks++; if (out_val32 !== 1'b0) begin errors++; $display("FAIL reset_out_val32: got %b exp 0", out_val32); end
    checks++; if (out_msg32 !== 32'h0) begin errors++; $display("FAIL reset_out_msg32: got %h exp 0", out_msg32); end
    checks++; if (out_err32 !== 1'b0) begin errors++; $display("FAIL reset_out_err32: got %b exp 0", out_err32); end
    checks++; if (in_rdy32 !== 1'b1) begin errors++; $display("FAIL reset_in_rdy32: got %b exp 1", in_rdy32); end
  endtask

  task automatic test_ops();
    logic [7:0]  exp5 [5] = '{8'hB0, 8'h12, 8'hF2, 8'hB4, 8'hD2};
    logic [31:0] m;
    logic        e;
    int          lat;
    for (int op = 0; op < 5; op++) begin
      run_one(32'h96, 3, op, m, e, lat);
      checks++; if (m !== {24'd0, exp5[op]}) begin errors++; $display("FAIL ops_msg op=%0d: got %h exp %h", op, m, exp5[op]); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL ops_err op=%0d: got %b exp 0", op, e); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL ops_latency op=%0d: got %0d exp 3", op, lat); end
    end
  endtask

  task automatic test_amt0_illegal();
    logic [31:0] m;
    logic        e;
    int          lat;
    for (int op = 0; op < 5; op++) begin
      run_one(32'h5A, 0, op, m, e, lat);
      checks++; if (m !== 32'h5A || e !== 1'b0) begin errors++; $display("FAIL amt0 op=%0d: got msg=%h err=%b exp msg=5a err=0", op, m, e); end
    end
    for (int op = 5; op < 8; op++) begin
      run_one(32'hFF, op - 4, op, m, e, lat);
      checks++; if (m !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL illegal op=%0d: got msg=%h err=%b exp msg=00 err=1", op, m, e); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL illegal_latency op=%0d: got %0d exp 3", op, lat); end
    end
  endtask

  // Random stream against a scoreboard; pval/prdy are percent probabilities.
  task automatic test_stream(input string name, input int n, input int pval,
                             input int prdy, input int w, input bit gapless);
    logic [32:0] q [$];
    logic [32:0] e;
    logic [31:0] hmsg;
    logic        herr;
    bit          hold;
    bit          acc;
    int          sent, got, cyc, first, last, extra;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1; extra = 0;
    hold = 1'b0; hmsg = '0; herr = 1'b0;
    sel32 = (w == 32);
    @(posedge clk); #1;
    while (got < n && cyc < 40 * n + 100) begin
      if (sent < n && $urandom_range(99) < pval) begin
        in_val = 1'b1;
        in_msg = $urandom;
        in_amt = 5'($urandom_range(w - 1));
        in_op  = 3'($urandom_range(7));
      end else begin
        in_val = 1'b0;
      end
      out_rdy = ($urandom_range(99) < prdy);
      @(negedge clk);
      acc = cur_in_rdy;
      if (hold) begin
        checks++;
        if (cur_out_val !== 1'b1 || cur_out_msg !== hmsg || cur_out_err !== herr) begin
          errors++;
          $display("FAIL %s_stable cyc=%0d: got val=%b msg=%h err=%b exp val=1 msg=%h err=%b",
                   name, cyc, cur_out_val, cur_out_msg, cur_out_err, hmsg, herr);
        end
      end
      hold = cur_out_val && !out_rdy;
      hmsg = cur_out_msg;
      herr = cur_out_err;
      if (cur_out_val && out_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra cyc=%0d: got msg=%h with nothing outstanding", name, cyc, cur_out_msg);
        end else begin
          e = q.pop_front();
          if ({cur_out_err, cur_out_msg} !== e) begin
            errors++;
            $display("FAIL %s_result #%0d: got err=%b msg=%h exp err=%b msg=%h",
                     name, got, cur_out_err, cur_out_msg, e[32], e[31:0]);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(posedge clk);
      if (in_val && acc) begin
        q.push_back(model(in_msg, int'(in_amt), int'(in_op), w));
        sent++;
      end
      #1 cyc++;
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    checks++; if (got !== n) begin errors++; $display("FAIL %s_count: got %0d results exp %0d", name, got, n); end
    if (gapless) begin
      checks++;
      if (last - first !== n - 1) begin errors++; $display("FAIL %s_gapless: got span %0d exp %0d", name, last - first, n - 1); end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cur_out_val) extra++;
      @(posedge clk);
    end
    #1;
    checks++; if (extra !== 0) begin errors++; $display("FAIL %s_idle: got %0d extra results exp 0", name, extra); end
    sel32 = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0]  m [4];
    int          a [4];
    int          o [4];
    logic [32:0] ex [4];
    logic [7:0]  obs [$];
    bit          r;
    for (int i = 0; i < 4; i++) begin
      m[i]  = 8'($urandom);
      a[i]  = $urandom_range(7);
      o[i]  = $urandom_range(4);
      ex[i] = model({24'd0, m[i]}, a[i], o[i], 8);
    end
    @(posedge clk); #1;
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1;
      in_msg = {24'd0, m[i]};
      in_amt = 5'(a[i]);
      in_op  = 3'(o[i]);
      @(negedge clk);
      r = in_rdy8;
      @(posedge clk); #1;
      checks++; if (r !== 1'b1) begin errors++; $display("FAIL stall_accept #%0d: got in_rdy=%b exp 1", i, r); end
    end
    in_msg = {24'd0, m[3]};
    in_amt = 5'(a[3]);
    in_op  = 3'(o[3]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (in_rdy8 !== 1'b0 || out_val8 !== 1'b1 || out_msg8 !== ex[0][7:0]) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: got rdy=%b val=%b msg=%h exp rdy=0 val=1 msg=%h",
                 c, in_rdy8, out_val8, out_msg8, ex[0][7:0]);
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    for (int c = 0; c < 12 && obs.size() < 4; c++) begin
      @(negedge clk);
      if (out_val8) obs.push_back(out_msg8);
      r = in_rdy8;
      @(posedge clk); #1;
      if (r) in_val = 1'b0;
    end
    in_val = 1'b0;
    checks++; if (obs.size() !== 4) begin errors++; $display("FAIL stall_drain_count: got %0d exp 4", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== ex[i][7:0]) begin errors++; $display("FAIL stall_drain #%0d: got %h exp %h", i, obs[i], ex[i][7:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] m;
    logic        e;
    int          lat;
    int          seen;
    logic        rdy_after;
    seen = 0;
    @(posedge clk); #1;
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = 32'h33; in_amt = 5'd1; in_op = 3'd0;
    @(posedge clk); #1;
    in_msg  = 32'h44; in_amt = 5'd2; in_op = 3'd3;
    @(posedge clk); #1;
    // Third request coincides with reset and must be discarded too.
    reset   = 1'b1;
    in_msg  = 32'h55; in_amt = 5'd1; in_op = 3'd1;
    @(posedge clk); #1;
    reset   = 1'b0;
    in_val  = 1'b0;
    @(negedge clk);
    rdy_after = in_rdy8;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (out_val8) seen++;
      @(posedge clk);
    end
    checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL midreset_in_rdy: got %b exp 1", rdy_after); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_flush: got %0d outputs exp 0", seen); end
    run_one(32'h01, 7, 0, m, e, lat);
    checks++; if (m !== 32'h80 || e !== 1'b0) begin errors++; $display("FAIL midreset_next: got msg=%h err=%b exp msg=80 err=0", m, e); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL midreset_latency: got %0d exp 3", lat); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_amt0_illegal();
    test_stream("back_to_back", 16, 100, 100, 8, 1'b1);
    test_stall();
    test_stream("random8", 1000, 50, 50, 8, 1'b0);
    test_stream("random32", 1000, 50, 50, 32, 1'b0);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
